// File: rtl/latency_fifo_if.sv
// Handshake bundle for latency_fifo: upstream push port, downstream pop port,
// flush control and occupancy report.
interface latency_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                         flush;
  logic                         req_in;
  logic                         accept_in;
  logic [WIDTH-1:0]             data_in;
  logic                         req_out;
  logic                         accept_out;
  logic [WIDTH-1:0]             data_out;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport master (
    output flush, req_in, data_in, accept_out,
    input  accept_in, req_out, data_out, level
  );

  modport slave (
    input  flush, req_in, data_in, accept_out,
    output accept_in, req_out, data_out, level
  );
endinterface

// File: rtl/latency_fifo.sv
// Ring-buffer FIFO where every entry matures for LATENCY cycles before it is
// offered downstream. Each slot carries its own countdown, so entries queued
// behind the head keep aging and leave back-to-back once the head pops.
module latency_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic          clk,
  input  logic          reset,
  latency_fifo_if.slave io_bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = 4;

  localparam logic [LW-1:0]    LEVEL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0]    LEVEL_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0]    PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LOAD   = CW'(LATENCY);
  localparam logic [WIDTH-1:0] DATA_ZERO  = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic             w_accept_in;
  logic             w_req_out;
  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  // Handshake flags come straight from registers: no path from req_in/accept_out.
  assign w_accept_in = (r_level < LEVEL_FULL);
  assign w_req_out   = (r_level != LEVEL_ZERO) && (r_cnt[r_rptr] == CNT_ZERO);
  assign w_push      = io_bus.req_in & w_accept_in;
  assign w_pop       = w_req_out & io_bus.accept_out;

  assign io_bus.accept_in = w_accept_in;
  assign io_bus.req_out   = w_req_out;
  assign io_bus.data_out  = r_mem[r_rptr];
  assign io_bus.level     = r_level;

  // Occupancy update: +1 on push only, -1 on pop only, hold otherwise.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LEVEL_ONE;
      2'b01:   w_level_nxt = r_level - LEVEL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointer and level registers; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= PTR_ZERO;
      r_rptr  <= PTR_ZERO;
      r_level <= LEVEL_ZERO;
    end else if (io_bus.flush) begin
      r_wptr  <= PTR_ZERO;
      r_rptr  <= PTR_ZERO;
      r_level <= LEVEL_ZERO;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_level <= w_level_nxt;
    end
  end

  // Slot payloads and per-slot maturity countdowns (load on write, saturate at 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_ZERO;
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && !io_bus.flush && (r_wptr == AW'(i))) begin
          r_mem[i] <= io_bus.data_in;
          r_cnt[i] <= CNT_LOAD;
        end else if (r_cnt[i] != CNT_ZERO) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  latency_fifo_chk #(
    .LW    (LW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .level (r_level)
  );
endmodule

// Simulation-only guards: a pop from an empty ring or a push into a full ring
// must never happen.
module latency_fifo_chk #(
  parameter int LW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic          pop,
  input logic [LW-1:0] level
);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && (level == {LW{1'b0}})));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (level == LW'(DEPTH))));
endmodule

// File: doc/latency_fifo.md
LATENCY_FIFO -- requirements
Module: latency_fifo

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, >= 1.
REQ-002 Parameter DEPTH, default 4: number of storage entries, a power of two, >= 2.
REQ-003 Parameter LATENCY, default 0, range 0..15: extra cycles an entry waits before it is offered downstream.
REQ-004 clk  input  1: clock, rising edge.
REQ-005 reset  input  1: reset, asynchronous, active-high.
REQ-006 flush  input  1: synchronous discard of all stored entries.
REQ-007 req_in  input  1: upstream offers data_in.
REQ-008 accept_in  output  1: block can take data this cycle.
REQ-009 data_in  input  WIDTH: upstream payload.
REQ-010 req_out  output  1: data_out is valid and mature.
REQ-011 accept_out  input  1: downstream takes data_out.
REQ-012 data_out  output  WIDTH: head-entry payload.
REQ-013 level  output  $clog2(DEPTH+1): number of stored entries.

Function
REQ-014 The block SHALL define push = req_in & accept_in and pop = req_out & accept_out, both evaluated at the rising clock edge.
REQ-015 Storage SHALL be a ring of DEPTH entries with a write pointer, a read pointer and an occupancy count; both pointers wrap from DEPTH-1 to 0.
REQ-016 accept_in SHALL be 1 exactly when level < DEPTH, decoded from registers only, with no combinational path from accept_out or req_in.
REQ-017 A full block SHALL NOT accept a push even if a pop occurs in the same cycle.
REQ-018 Each entry SHALL carry a countdown loaded with LATENCY on push, decremented by 1 per cycle while nonzero, and saturating at 0.
REQ-019 req_out SHALL be 1 exactly when level > 0 and the head entry's countdown is 0, decoded from registers only.
REQ-020 An entry pushed at edge t SHALL first be offered (req_out=1) in the cycle after edge t+LATENCY; with LATENCY=0 this is one cycle after the push.
REQ-021 Latency SHALL be measured per entry; an entry blocked behind the head SHALL keep aging and is offered immediately after the head pops if its countdown is already 0.
REQ-022 data_out SHALL equal the head entry's payload whenever level > 0, and SHALL stay stable while req_out=1 and accept_out=0.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-024 level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-025 Order SHALL be strictly first-in first-out; no entry is dropped or duplicated except by flush or reset.
REQ-026 flush=1 at an edge SHALL zero level and both pointers and SHALL take precedence over a same-cycle push and pop, so the data presented that cycle is discarded.
REQ-027 With flush=1, accept_in and req_out SHALL still follow REQ-016 and REQ-019 from the pre-flush state.
REQ-028 A pop while level=0 or a push while level=DEPTH SHALL be impossible by construction; simulation-only assertions SHALL flag either condition.

Reset
REQ-029 Asserting reset SHALL immediately clear level, the pointers, all countdowns and all storage to 0, independent of clk.
REQ-030 During and after reset, outputs SHALL be: accept_in=1, req_out=0, level=0, data_out=0.
REQ-031 Entries in flight when reset asserts SHALL be lost; the first push after release SHALL behave as a push into an empty block.

Verification
REQ-032 Scenario 1: DEPTH=4, LATENCY=0, push 0xA at edge 1 with accept_out=1 -> req_out=1 and data_out=0xA in the cycle after edge 1; pop at edge 2; level returns to 0.
REQ-033 Scenario 2: LATENCY=3, push 0x11 at edge 5 -> req_out=0 through edge 8, and req_out=1 with data_out=0x11 in the cycle after edge 8.
REQ-034 Scenario 3: DEPTH=4, accept_out=0, push 0x1..0x5 on consecutive cycles -> 0x1..0x4 accepted, accept_in=0 once level=4, 0x5 held upstream; then accept_out=1 -> output order 0x1,0x2,0x3,0x4,0x5.
REQ-035 Scenario 4: level=2 with continuous push and pop for 10 cycles -> level stays 2, output order matches input order, pointers wrap without error.
REQ-036 Scenario 5: level=3, flush asserted together with push and pop -> level=0 next cycle, req_out=0, and the pushed word is never output.
REQ-037 Scenario 6: reset asserted mid-cycle with level=2 -> outputs match REQ-030 before the next edge; a push after release is offered per REQ-020.
